riscv_v_csr_ctrl: RTL and testbench

RISCV_V_CSR_CTRL -- requirements
Module: riscv_v_csr_ctrl

---
 rtl/riscv_v_csr_ctrl_if.sv | 26 ++
 rtl/riscv_v_csr_ctrl.sv | 136 +++++++++++++
 tb/tb_riscv_v_csr_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_v_csr_ctrl_if.sv
// riscv_v_csr_ctrl_if: request/response handshake bundle between an issue stage and the vector CSR controller
interface riscv_v_csr_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_avl;
    logic [31:0] req_vtype;
    logic        req_rs1_x0;
    logic        req_rd_x0;
    logic [11:0] req_csr_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;

    modport master (
        output req_valid, req_op, req_avl, req_vtype, req_rs1_x0, req_rd_x0, req_csr_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_illegal
    );

    modport slave (
        input  req_valid, req_op, req_avl, req_vtype, req_rs1_x0, req_rd_x0, req_csr_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_illegal
    );
endinterface

// File: rtl/riscv_v_csr_ctrl.sv
// riscv_v_csr_ctrl: sequences vset*/Zicsr vector CSR instructions into one-cycle CSR write pulses and a response
module riscv_v_csr_ctrl #(
    parameter int VLEN = 128
) (
    input  logic              clk,
    input  logic              rst,
    riscv_v_csr_ctrl_if.slave bus,
    output logic [31:0]       vtype_data_in,
    output logic              vtype_wr_en,
    input  logic [31:0]       vtype_data_out,
    output logic [31:0]       vl_data_in,
    output logic              vl_wr_en,
    input  logic [31:0]       vl_data_out,
    output logic [31:0]       vstart_data_in,
    output logic              vstart_wr_en,
    input  logic [31:0]       vstart_data_out,
    output logic [1:0]        vxrm_data_in,
    output logic              vxrm_wr_en,
    input  logic [1:0]        vxrm_data_out,
    output logic              vxsat_data_in,
    output logic              vxsat_wr_en,
    input  logic              vxsat_data_out,
    input  logic [31:0]       vlenb_data_out,
    input  logic [2:0]        vcsr_data_out
);
    typedef enum logic [1:0] {IDLE, EXEC, WRITE, RESP} state_t;

    localparam logic [2:0] OP_VSETIVLI = 3'd1;
    localparam logic [2:0] OP_VSETVL   = 3'd2;
    localparam logic [2:0] OP_CSRRW    = 3'd3;
    localparam logic [2:0] OP_CSRRS    = 3'd4;
    localparam logic [2:0] OP_CSRRC    = 3'd5;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [31:0] avl_q, vtype_q, wdata_q;
    logic        rs1_x0_q, rd_x0_q;
    logic [11:0] addr_q;
    logic [4:0]  we_q, we_c;
    logic [31:0] rdata_q, rdata_c;
    logic        illegal_q, illegal_c;
    logic        vill, keep_vl, mapped, ro, wr_try, csr_ok, is_vset;
    logic [31:0] vlmax, avl_eff, vl_new, old, nv;

    // Result of the captured instruction against the current CSR outputs
    always_comb begin
        is_vset = op_q <= OP_VSETVL;
        vill = |vtype_q[2:0] || vtype_q[5] || |vtype_q[31:8];
        vlmax = 32'(VLEN) >> ({2'b0, vtype_q[5:3]} + 5'd3);
        avl_eff = (op_q == OP_VSETIVLI || !rs1_x0_q) ? avl_q : vlmax;
        keep_vl = op_q != OP_VSETIVLI && rs1_x0_q && rd_x0_q && !vill;
        vl_new = vill ? '0 : keep_vl ? vl_data_out : (avl_eff < vlmax ? avl_eff : vlmax);
        mapped = 1'b1;
        old = '0;
        case (addr_q)
            12'h008: old = vstart_data_out;
            12'h009: old = {31'b0, vxsat_data_out};
            12'h00A: old = {30'b0, vxrm_data_out};
            12'h00F: old = {29'b0, vcsr_data_out};
            12'hC20: old = vl_data_out;
            12'hC21: old = vtype_data_out;
            12'hC22: old = vlenb_data_out;
            default: mapped = 1'b0;
        endcase
        ro = addr_q[11:10] == 2'b11;
        wr_try = op_q == OP_CSRRW || !rs1_x0_q;
        nv = op_q == OP_CSRRW ? wdata_q : op_q == OP_CSRRS ? (old | wdata_q) : (old & ~wdata_q);
        csr_ok = mapped && !(ro && wr_try) && op_q <= OP_CSRRC;
        illegal_c = !is_vset && !csr_ok;
        rdata_c = is_vset ? vl_new : csr_ok ? old : '0;
        we_c = is_vset ? {1'b1, !keep_vl, 1'b1, 2'b00}
             : (csr_ok && wr_try) ? {2'b00, addr_q == 12'h008, addr_q == 12'h00A || addr_q == 12'h00F,
                                     addr_q == 12'h009 || addr_q == 12'h00F}
             : 5'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            op_q           <= '0;
            avl_q          <= '0;
            vtype_q        <= '0;
            wdata_q        <= '0;
            rs1_x0_q       <= 1'b0;
            rd_x0_q        <= 1'b0;
            addr_q         <= '0;
            we_q           <= '0;
            rdata_q        <= '0;
            illegal_q      <= 1'b0;
            vtype_data_in  <= '0;
            vl_data_in     <= '0;
            vstart_data_in <= '0;
            vxrm_data_in   <= '0;
            vxsat_data_in  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.req_valid) begin
                op_q     <= bus.req_op;
                avl_q    <= bus.req_avl;
                vtype_q  <= bus.req_vtype;
                wdata_q  <= bus.req_wdata;
                rs1_x0_q <= bus.req_rs1_x0;
                rd_x0_q  <= bus.req_rd_x0;
                addr_q   <= bus.req_csr_addr;
            end
            if (state == EXEC) begin
                we_q           <= we_c;
                rdata_q        <= rdata_c;
                illegal_q      <= illegal_c;
                vtype_data_in  <= vill ? 32'h8000_0000 : {24'b0, vtype_q[7:0]};
                vl_data_in     <= vl_new;
                vstart_data_in <= is_vset ? '0 : nv;
                vxrm_data_in   <= addr_q == 12'h00F ? nv[2:1] : nv[1:0];
                vxsat_data_in  <= nv[0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.req_valid ? EXEC : IDLE;
            EXEC:    state_nxt = WRITE;
            WRITE:   state_nxt = RESP;
            RESP:    state_nxt = bus.rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Write enables are decoded from state so an async reset drops them at once
    assign {vtype_wr_en, vl_wr_en, vstart_wr_en, vxrm_wr_en, vxsat_wr_en} = state == WRITE ? we_q : 5'b0;
    assign bus.req_ready   = state == IDLE;
    assign bus.rsp_valid   = state == RESP;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_illegal = illegal_q;
endmodule

// File: tb/tb_riscv_v_csr_ctrl.sv
// tb_riscv_v_csr_ctrl: directed and random vector CSR instructions checked against an architectural model
module tb_riscv_v_csr_ctrl;
    localparam int VLEN = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    riscv_v_csr_ctrl_if bus();

    logic [31:0] vtype_data_in, vl_data_in, vstart_data_in;
    logic        vtype_wr_en, vl_wr_en, vstart_wr_en, vxrm_wr_en, vxsat_wr_en;
    logic [1:0]  vxrm_data_in;
    logic        vxsat_data_in;

    // CSR file the controller talks to
    logic [31:0] e_vtype = '0, e_vl = '0, e_vstart = '0;
    logic [1:0]  e_vxrm = '0;
    logic        e_vxsat = 1'b0;
    always @(posedge clk) begin
        if (vtype_wr_en) e_vtype <= vtype_data_in;
        if (vl_wr_en) e_vl <= vl_data_in;
        if (vstart_wr_en) e_vstart <= vstart_data_in;
        if (vxrm_wr_en) e_vxrm <= vxrm_data_in;
        if (vxsat_wr_en) e_vxsat <= vxsat_data_in;
    end

    riscv_v_csr_ctrl #(.VLEN(VLEN)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .vtype_data_in(vtype_data_in), .vtype_wr_en(vtype_wr_en), .vtype_data_out(e_vtype),
        .vl_data_in(vl_data_in), .vl_wr_en(vl_wr_en), .vl_data_out(e_vl),
        .vstart_data_in(vstart_data_in), .vstart_wr_en(vstart_wr_en), .vstart_data_out(e_vstart),
        .vxrm_data_in(vxrm_data_in), .vxrm_wr_en(vxrm_wr_en), .vxrm_data_out(e_vxrm),
        .vxsat_data_in(vxsat_data_in), .vxsat_wr_en(vxsat_wr_en), .vxsat_data_out(e_vxsat),
        .vlenb_data_out(32'(VLEN / 8)), .vcsr_data_out({e_vxrm, e_vxsat})
    );

    logic [4:0] wev;
    assign wev = {vtype_wr_en, vl_wr_en, vstart_wr_en, vxrm_wr_en, vxsat_wr_en};

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Architectural state as the instruction set defines it
    logic [31:0] m_vtype = '0, m_vl = '0, m_vstart = '0;
    logic [1:0]  m_vxrm = '0;
    logic        m_vxsat = 1'b0;

    task automatic model(input logic [2:0] op, input logic [31:0] avl, vt, input bit r1z, rdz,
                         input logic [11:0] a, input logic [31:0] wd,
                         output logic [31:0] erd, output bit eill, output logic [4:0] ewe);
        int sew;
        logic [31:0] vlmax, old, nv;
        bit mapped, ro, wr;
        erd = '0; eill = 0; ewe = '0;
        if (op <= 2) begin
            sew = 8 << vt[5:3];
            vlmax = 32'(VLEN / sew);
            ewe = 5'b10100;
            m_vstart = '0;
            if (vt[2:0] != 0 || sew > 64 || vt[31:8] != 0) begin
                m_vtype = 32'h8000_0000;
                m_vl = '0;
                ewe[3] = 1'b1;
            end else begin
                m_vtype = vt & 32'hFF;
                ewe[3] = 1'b1;
                if (op == 1 || !r1z) m_vl = avl < vlmax ? avl : vlmax;
                else if (!rdz) m_vl = vlmax;
                else ewe[3] = 1'b0;
            end
            erd = m_vl;
        end else begin
            mapped = 1;
            old = '0;
            case (a)
                12'h008: old = m_vstart;
                12'h009: old = {31'b0, m_vxsat};
                12'h00A: old = {30'b0, m_vxrm};
                12'h00F: old = {29'b0, m_vxrm, m_vxsat};
                12'hC20: old = m_vl;
                12'hC21: old = m_vtype;
                12'hC22: old = 32'(VLEN / 8);
                default: mapped = 0;
            endcase
            ro = a >= 12'hC00;
            wr = op == 3 || !r1z;
            if (op > 5 || !mapped || (ro && wr)) begin
                eill = 1;
            end else begin
                erd = old;
                if (wr) begin
                    nv = op == 3 ? wd : op == 4 ? (old | wd) : (old & ~wd);
                    case (a)
                        12'h008: begin m_vstart = nv; ewe = 5'b00100; end
                        12'h009: begin m_vxsat = nv[0]; ewe = 5'b00001; end
                        12'h00A: begin m_vxrm = nv[1:0]; ewe = 5'b00010; end
                        default: begin m_vxrm = nv[2:1]; m_vxsat = nv[0]; ewe = 5'b00011; end
                    endcase
                end
            end
        end
    endtask

    task automatic junk();
        bus.req_valid    = 1'($urandom);
        bus.req_op       = 3'($urandom);
        bus.req_avl      = $urandom;
        bus.req_vtype    = $urandom;
        bus.req_rs1_x0   = 1'($urandom);
        bus.req_rd_x0    = 1'($urandom);
        bus.req_csr_addr = 12'($urandom);
        bus.req_wdata    = $urandom;
    endtask

    task automatic check_state(input string tag);
        check(tag, {e_vtype, e_vl, e_vstart, e_vxrm, e_vxsat}, {m_vtype, m_vl, m_vstart, m_vxrm, m_vxsat});
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] avl, vt, input bit r1z, rdz,
                       input logic [11:0] a, input logic [31:0] wd, input int hold);
        logic [31:0] erd, rd0;
        bit eill;
        logic [4:0] ewe;
        check("req_ready_idle", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_avl = avl; bus.req_vtype = vt;
        bus.req_rs1_x0 = r1z; bus.req_rd_x0 = rdz; bus.req_csr_addr = a; bus.req_wdata = wd;
        bus.rsp_ready = 1'b0;
        @(posedge clk) #1;
        junk();
        check("exec_no_we", wev, 5'b0);
        check("exec_busy", {bus.req_ready, bus.rsp_valid}, 2'b00);
        @(posedge clk) #1;
        junk();
        model(op, avl, vt, r1z, rdz, a, wd, erd, eill, ewe);
        check("write_we", wev, ewe);
        if (ewe[3]) check("vl_data_in", vl_data_in, m_vl);
        if (ewe[4]) check("vtype_data_in", vtype_data_in, m_vtype);
        @(posedge clk) #1;
        check("rsp_valid", bus.rsp_valid, 1'b1);
        check("rsp_rdata", bus.rsp_rdata, erd);
        check("rsp_illegal", bus.rsp_illegal, eill);
        check("resp_no_we", wev, 5'b0);
        rd0 = bus.rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            junk();
            @(posedge clk) #1;
            check("hold_valid", bus.rsp_valid, 1'b1);
            check("hold_rdata", bus.rsp_rdata, rd0);
            check("hold_ready", bus.req_ready, 1'b0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk) #1;
        bus.rsp_ready = 1'b0;
        check("done_idle", {bus.rsp_valid, bus.req_ready}, 2'b01);
        check_state("csr_state");
    endtask

    logic [11:0] addrs [7] = '{12'h008, 12'h009, 12'h00A, 12'h00F, 12'hC20, 12'hC21, 12'hC22};

    initial begin
        logic [2:0]  op;
        logic [31:0] vt, avl, wd;
        logic [11:0] a;
        bus.req_valid = 0; bus.req_op = 0; bus.req_avl = 0; bus.req_vtype = 0;
        bus.req_rs1_x0 = 0; bus.req_rd_x0 = 0; bus.req_csr_addr = 0; bus.req_wdata = 0;
        bus.rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.req_ready, 1'b1);
        check("rst_valid", bus.rsp_valid, 1'b0);
        check("rst_rdata", bus.rsp_rdata, 32'h0);
        check("rst_illegal", bus.rsp_illegal, 1'b0);
        check("rst_we", wev, 5'b0);
        rst = 1'b0;
        @(posedge clk) #1;

        run(3'd0, 32'd100, 32'h10, 0, 0, 12'h0, 32'h0, 0);
        check("vsetvli_vl4", e_vl, 32'd4);
        run(3'd0, 32'd0, 32'h00, 1, 0, 12'h0, 32'h0, 1);
        check("vlmax_sew8", e_vl, 32'd16);
        run(3'd0, 32'd0, 32'h08, 1, 1, 12'h0, 32'h0, 0);
        run(3'd2, 32'd50, 32'h01, 0, 0, 12'h0, 32'h0, 0);
        check("vill_vtype", e_vtype, 32'h8000_0000);
        run(3'd1, 32'd9, 32'h18, 0, 0, 12'h0, 32'h0, 0);
        run(3'd3, 32'd0, 32'h0, 0, 0, 12'h00F, 32'h5, 0);
        check("vcsr_split", {e_vxrm, e_vxsat}, 3'b101);
        run(3'd4, 32'd0, 32'h0, 1, 0, 12'hC20, 32'h0, 2);
        run(3'd3, 32'd0, 32'h0, 0, 0, 12'hC21, 32'h7, 5);
        run(3'd6, 32'd0, 32'h0, 0, 0, 12'h008, 32'h7, 0);
        run(3'd5, 32'd0, 32'h0, 0, 0, 12'h123, 32'h7, 0);

        // Reset during WRITE must abort the instruction without side effects
        bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_avl = 32'd7; bus.req_vtype = 32'h08;
        bus.req_rs1_x0 = 1'b0; bus.req_rd_x0 = 1'b0;
        @(posedge clk) #1;
        bus.req_valid = 1'b0;
        @(posedge clk) #1;
        check("abort_we_pre", wev, 5'b11100);
        rst = 1'b1;
        #1;
        check("abort_we_drop", wev, 5'b0);
        check("abort_ready", bus.req_ready, 1'b1);
        @(posedge clk) #1;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk) #1;
            check("abort_no_rsp", bus.rsp_valid, 1'b0);
        end
        bus.rsp_ready = 1'b0;
        check_state("abort_state");

        for (int n = 0; n < 200; n++) begin
            op  = $urandom_range(0, 9) == 0 ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            vt  = $urandom_range(0, 4) == 0 ? $urandom : {24'b0, 2'($urandom), 3'($urandom_range(0, 3)), 3'b0};
            avl = $urandom_range(0, 1) == 1 ? 32'($urandom_range(0, 40)) : $urandom;
            a   = $urandom_range(0, 7) == 0 ? 12'($urandom) : addrs[$urandom_range(0, 6)];
            wd  = $urandom_range(0, 1) == 1 ? 32'($urandom_range(0, 7)) : $urandom;
            run(op, avl, vt, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, a, wd, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
